// File: rtl/seqgen_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seqgen_arb_pkg
// Brief    : Shared types and default pattern constants for seqgen_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package seqgen_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FIRE = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int c_seq_len = 6;
   // Bit k is the generator output expected in pattern cycle k (cycle 0 = trigger).
   localparam logic [c_seq_len-1:0] c_exp_pattern = 6'b110001;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker; first set req bit after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   output logic [N_REQ-1:0]         onehot,
   output logic [$clog2(N_REQ)-1:0] idx
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [IDX_W:0]   c_n   = (IDX_W+1)'(N_REQ);
   localparam logic [N_REQ-1:0] c_one = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [IDX_W:0] w_pos;
   logic           w_found;

   // One extra bit holds ptr+i before the modulo wrap.
   always_comb begin
      onehot  = '0;
      idx     = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         w_pos = {1'b0, ptr} + (IDX_W+1)'(i);
         if (w_pos >= c_n) begin
            w_pos = w_pos - c_n;
         end
         if (!w_found && req[w_pos[IDX_W-1:0]]) begin
            w_found = 1'b1;
            onehot  = c_one << w_pos;
            idx     = w_pos[IDX_W-1:0];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/seqgen_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seqgen_arbiter
// Brief    : Round-robin sharing of one sequence_gen; triggers, routes, checks.
// Revision : 1.0 - initial release
// ============================================================================
module seqgen_arbiter
   import seqgen_arb_pkg::*;
#(
   parameter int                 N_REQ       = 4,
   parameter int                 SEQ_LEN     = c_seq_len,
   parameter logic [SEQ_LEN-1:0] EXP_PATTERN = c_exp_pattern
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] seq_out,
   output logic             busy,
   output logic             err,
   output logic             seq_i,
   input  logic             seq_o
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(SEQ_LEN);
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SEQ_LEN-1);
   localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
   localparam logic [IDX_W-1:0] c_ptr_rst  = IDX_W'(N_REQ-1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N_REQ-1:0] r_grant;
   logic [IDX_W-1:0] r_ptr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;

   logic [N_REQ-1:0] w_win_onehot;
   logic [IDX_W-1:0] w_win_idx;
   logic             w_any_req;
   logic             w_checking;
   logic             w_mismatch;

   rr_pick #(
      .N_REQ (N_REQ)
   ) u_rr_pick (
      .req    (req),
      .ptr    (r_ptr),
      .onehot (w_win_onehot),
      .idx    (w_win_idx)
   );

   assign w_any_req  = |req;
   assign w_checking = (r_state == FIRE) || (r_state == RUN);
   // r_cnt is the current pattern cycle index in both FIRE (0) and RUN.
   assign w_mismatch = w_checking && (seq_o != EXP_PATTERN[r_cnt]);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_any_req) w_state_nxt = FIRE;
         FIRE:    w_state_nxt = RUN;
         RUN:     if (r_cnt == c_cnt_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      seq_i = (r_state == FIRE);
      busy  = (r_state != IDLE);
      done  = (r_state == DONE) ? r_grant : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant <= '0;
         r_ptr   <= c_ptr_rst;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (w_any_req) begin
                  r_grant <= w_win_onehot;
                  r_ptr   <= w_win_idx;
               end
            end
            FIRE: r_cnt <= c_cnt_one;
            RUN: begin
               if (r_cnt == c_cnt_last) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + c_cnt_one;
               end
            end
            DONE:    r_grant <= '0;
            default: r_cnt <= '0;
         endcase
         if (w_mismatch) begin
            r_err <= 1'b1;
         end
      end
   end

   assign grant   = r_grant;
   assign err     = r_err;
   assign seq_out = {N_REQ{seq_o}} & r_grant;

endmodule
`default_nettype wire

// File: tb/tb_seqgen_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seqgen_arbiter
// Brief    : Directed bench for seqgen_arbiter with a behavioural generator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seqgen_arbiter;

   localparam logic [5:0] c_pat = 6'b110001;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic [3:0] req     = 4'b0000;
   logic       inj_err = 1'b0;
   logic [3:0] grant, done, seq_out;
   logic       busy, err, seq_i, seq_o;

   logic       gen_active;
   logic [2:0] gen_idx;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seqgen_arbiter #(
      .N_REQ       (4),
      .SEQ_LEN     (6),
      .EXP_PATTERN (c_pat)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .grant   (grant),
      .done    (done),
      .seq_out (seq_out),
      .busy    (busy),
      .err     (err),
      .seq_i   (seq_i),
      .seq_o   (seq_o)
   );

   // Generator model: pattern cycle 0 is combinational on the trigger cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         gen_active <= 1'b0;
         gen_idx    <= 3'd0;
      end else if (seq_i) begin
         gen_active <= 1'b1;
         gen_idx    <= 3'd1;
      end else if (gen_active) begin
         if (gen_idx == 3'd5) begin
            gen_active <= 1'b0;
            gen_idx    <= 3'd0;
         end else begin
            gen_idx <= gen_idx + 3'd1;
         end
      end
   end

   always_comb begin
      if (seq_i) begin
         seq_o = c_pat[0];
      end else if (gen_active) begin
         seq_o = c_pat[gen_idx] & ~(inj_err && (gen_idx == 3'd4));
      end else begin
         seq_o = 1'b0;
      end
   end

   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
      logic [3:0] done;
      logic [3:0] seq_out;
      logic       busy;
      logic       seq_i;
      logic       err;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset(input logic [3:0] r);
      reset = 1'b1;
      req   = r;
      tick();
      tick();
      reset = 1'b0;
   endtask

   logic [3:0] rot_grant [8];
   int         rot_cyc   [8];
   int         n_rise;
   int         leak;
   logic [3:0] prev_grant;

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Single request on requester 2 starting at cycle t (vector 0 drives it).
      vecs[0] = '{4'b0100, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
      vecs[5] = '{4'b0000, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};

      do_reset(4'b0000);
      check("rst grant",   32'(grant),   32'h0);
      check("rst done",    32'(done),    32'h0);
      check("rst seq_out", 32'(seq_out), 32'h0);
      check("rst busy",    32'(busy),    32'h0);
      check("rst seq_i",   32'(seq_i),   32'h0);
      check("rst err",     32'(err),     32'h0);

      for (int i = 0; i < 9; i++) begin
         req = vecs[i].req;
         tick();
         check($sformatf("vec%0d grant", i),   32'(grant),   32'(vecs[i].grant));
         check($sformatf("vec%0d done", i),    32'(done),    32'(vecs[i].done));
         check($sformatf("vec%0d seq_out", i), 32'(seq_out), 32'(vecs[i].seq_out));
         check($sformatf("vec%0d busy", i),    32'(busy),    32'(vecs[i].busy));
         check($sformatf("vec%0d seq_i", i),   32'(seq_i),   32'(vecs[i].seq_i));
         check($sformatf("vec%0d err", i),     32'(err),     32'(vecs[i].err));
      end

      // Rotation with all requests held from reset.
      do_reset(4'b1111);
      n_rise     = 0;
      leak       = 0;
      prev_grant = 4'b0000;
      for (int c = 1; c <= 45; c++) begin
         tick();
         if ((seq_out & ~grant) != 4'b0000) leak++;
         if (prev_grant == 4'b0000 && grant != 4'b0000 && n_rise < 8) begin
            rot_grant[n_rise] = grant;
            rot_cyc[n_rise]   = c;
            n_rise++;
         end
         prev_grant = grant;
      end
      check("rot grants seen", 32'(n_rise), 32'd6);
      check("rot seq_out leak", 32'(leak), 32'd0);
      if (n_rise >= 6) begin
         check("rot g0", 32'(rot_grant[0]), 32'b0001);
         check("rot g1", 32'(rot_grant[1]), 32'b0010);
         check("rot g2", 32'(rot_grant[2]), 32'b0100);
         check("rot g3", 32'(rot_grant[3]), 32'b1000);
         check("rot g4", 32'(rot_grant[4]), 32'b0001);
         check("rot first cycle", 32'(rot_cyc[0]), 32'd1);
         for (int k = 1; k < 6; k++) begin
            check($sformatf("rot gap%0d", k), 32'(rot_cyc[k] - rot_cyc[k-1]), 32'd8);
         end
      end

      // Late request: req[1] raised while requester 3 is in RUN.
      do_reset(4'b1000);
      tick();
      check("late grant3", 32'(grant), 32'b1000);
      tick();
      tick();
      req = 4'b1010;
      repeat (3) tick();
      tick();
      check("late done3",  32'(done),  32'b1000);
      check("late held3",  32'(grant), 32'b1000);
      tick();
      check("late idle grant", 32'(grant), 32'b0000);
      check("late idle busy",  32'(busy),  32'b0);
      tick();
      check("late grant1", 32'(grant), 32'b0010);
      check("late seq_i1", 32'(seq_i), 32'b1);

      // Reset pulsed at RUN cycle 3.
      do_reset(4'b0001);
      repeat (4) tick();
      check("mid busy pre", 32'(busy), 32'b1);
      reset = 1'b1;
      req   = 4'b0000;
      tick();
      check("mid grant", 32'(grant), 32'b0000);
      check("mid busy",  32'(busy),  32'b0);
      check("mid seq_i", 32'(seq_i), 32'b0);
      check("mid done",  32'(done),  32'b0000);
      reset = 1'b0;
      req   = 4'b0001;
      tick();
      check("mid regrant", 32'(grant), 32'b0001);
      repeat (5) tick();
      req = 4'b0000;
      tick();
      check("mid redone", 32'(done), 32'b0001);
      check("mid err",    32'(err),  32'b0);

      // Error injection at pattern cycle 4.
      inj_err = 1'b1;
      do_reset(4'b0001);
      repeat (5) tick();
      check("inj err before", 32'(err), 32'b0);
      tick();
      check("inj err set", 32'(err), 32'b1);
      req = 4'b0000;
      tick();
      check("inj done",    32'(done), 32'b0001);
      check("inj err hold", 32'(err), 32'b1);
      repeat (2) tick();
      check("inj err sticky", 32'(err), 32'b1);
      check("inj idle busy",  32'(busy), 32'b0);
      inj_err = 1'b0;

      // Dropped request: requester 0 released during RUN.
      do_reset(4'b0011);
      tick();
      check("drop grant0", 32'(grant), 32'b0001);
      tick();
      req = 4'b0010;
      repeat (4) tick();
      tick();
      check("drop done0", 32'(done), 32'b0001);
      req = 4'b0011;
      tick();
      check("drop idle busy", 32'(busy), 32'b0);
      tick();
      check("drop next grant", 32'(grant), 32'b0010);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
